// File: rtl/downsampler_mc.sv
// downsampler_mc: TDM multichannel frame decimator with a one-deep AXI-Stream output register.
// Define DOWNSAMPLER_MC_FRAME_CHECK_EN to add the sticky err_framing output.
module downsampler_mc #(
  parameter int  DATA_WIDTH = 16,
  parameter int  NUM_CH     = 4,
  parameter int  MAX_R      = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int R_W        = $clog2(MAX_R + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [R_W-1:0]        cfg_ratio,
  input  logic [DATA_WIDTH-1:0] s_axis_in_tdata,
  input  logic                  s_axis_in_tvalid,
  output logic                  s_axis_in_tready,
  input  logic                  s_axis_in_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_out_tdata,
  output logic                  m_axis_out_tvalid,
  input  logic                  m_axis_out_tready,
  output logic                  m_axis_out_tlast,
  output logic [CH_W-1:0]       m_axis_out_tuser
`ifdef DOWNSAMPLER_MC_FRAME_CHECK_EN
  ,
  output logic                  err_framing
`endif
);

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [R_W-1:0]  RATIO_MAX = R_W'(MAX_R);

  logic [CH_W-1:0]       ch_q, ch_d;
  logic [R_W-1:0]        fcnt_q, fcnt_d;
  logic [R_W-1:0]        ratio_q, ratio_d;
  logic                  load_q;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [CH_W-1:0]       out_user_q, out_user_d;
  logic                  accept_s;
  logic                  last_frame_s;
  logic [R_W-1:0]        ratio_eff_s;

  function automatic logic [R_W-1:0] clamp_ratio(input logic [R_W-1:0] r);
    logic [R_W-1:0] res;
    if (r == '0) begin
      res = R_W'(1);
    end else if (r > RATIO_MAX) begin
      res = RATIO_MAX;
    end else begin
      res = r;
    end
    return res;
  endfunction

  assign s_axis_in_tready = !out_valid_q || m_axis_out_tready;
  assign accept_s         = s_axis_in_tvalid && s_axis_in_tready;
  // On the first cycle out of reset the group ratio comes straight from cfg_ratio.
  assign ratio_eff_s      = load_q ? clamp_ratio(cfg_ratio) : ratio_q;
  assign last_frame_s     = (fcnt_q == (ratio_eff_s - R_W'(1)));

  always_comb begin
    ch_d        = ch_q;
    fcnt_d      = fcnt_q;
    ratio_d     = ratio_eff_s;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    if (accept_s) begin
      if (s_axis_in_tlast) begin
        ch_d = '0;
        if (last_frame_s) begin
          fcnt_d  = '0;
          ratio_d = clamp_ratio(cfg_ratio);
        end else begin
          fcnt_d = fcnt_q + R_W'(1);
        end
      end else if (ch_q != CH_LAST) begin
        ch_d = ch_q + CH_W'(1);
      end else begin
        ch_d = ch_q;
      end
    end else begin
      ch_d = ch_q;
    end
    if (accept_s && last_frame_s) begin
      out_valid_d = 1'b1;
      out_data_d  = s_axis_in_tdata;
      out_last_d  = s_axis_in_tlast;
      out_user_d  = ch_q;
    end else if (m_axis_out_tready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q        <= '0;
      fcnt_q      <= '0;
      ratio_q     <= R_W'(1);
      load_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= '0;
    end else begin
      ch_q        <= ch_d;
      fcnt_q      <= fcnt_d;
      ratio_q     <= ratio_d;
      load_q      <= 1'b0;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
    end
  end

  assign m_axis_out_tvalid = out_valid_q;
  assign m_axis_out_tdata  = out_data_q;
  assign m_axis_out_tlast  = out_last_q;
  assign m_axis_out_tuser  = out_user_q;

`ifdef DOWNSAMPLER_MC_FRAME_CHECK_EN
  logic err_q, err_d;

  // Flag tlast on any channel but the last, or a missing tlast on the last channel.
  always_comb begin
    err_d = err_q;
    if (accept_s && ((s_axis_in_tlast && (ch_q != CH_LAST)) ||
                     (!s_axis_in_tlast && (ch_q == CH_LAST)))) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_framing = err_q;
`endif

endmodule

// File: tb/tb_downsampler_mc.sv
// Bench for downsampler_mc: directed scenarios plus randomized traffic against a queue-based frame model.
// Two instances (NUM_CH=2 and NUM_CH=4) share the stimulus; 'sel' picks the one under check.
`timescale 1ns/1ps
module tb_downsampler_mc;
  localparam int DW    = 16;
  localparam int MAX_R = 16;
  localparam int R_W   = 5;

  typedef struct packed {
    logic [1:0]    user;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic reset, m_tready, s_tvalid, s_tlast, sel;
  logic [R_W-1:0] cfg;
  logic [DW-1:0]  s_tdata;

  logic d2_sready, d2_valid, d2_last, d2_user;
  logic [DW-1:0] d2_data;
  logic d4_sready, d4_valid, d4_last;
  logic [1:0] d4_user;
  logic [DW-1:0] d4_data;
`ifdef DOWNSAMPLER_MC_FRAME_CHECK_EN
  logic d2_err, d4_err, o_err;
`endif

  downsampler_mc #(.DATA_WIDTH(DW), .NUM_CH(2), .MAX_R(MAX_R)) u_dut2 (
    .clk(clk), .reset(reset), .cfg_ratio(cfg),
    .s_axis_in_tdata(s_tdata), .s_axis_in_tvalid(s_tvalid),
    .s_axis_in_tready(d2_sready), .s_axis_in_tlast(s_tlast),
    .m_axis_out_tdata(d2_data), .m_axis_out_tvalid(d2_valid),
    .m_axis_out_tready(m_tready), .m_axis_out_tlast(d2_last),
    .m_axis_out_tuser(d2_user)
`ifdef DOWNSAMPLER_MC_FRAME_CHECK_EN
    , .err_framing(d2_err)
`endif
  );

  downsampler_mc #(.DATA_WIDTH(DW), .NUM_CH(4), .MAX_R(MAX_R)) u_dut4 (
    .clk(clk), .reset(reset), .cfg_ratio(cfg),
    .s_axis_in_tdata(s_tdata), .s_axis_in_tvalid(s_tvalid),
    .s_axis_in_tready(d4_sready), .s_axis_in_tlast(s_tlast),
    .m_axis_out_tdata(d4_data), .m_axis_out_tvalid(d4_valid),
    .m_axis_out_tready(m_tready), .m_axis_out_tlast(d4_last),
    .m_axis_out_tuser(d4_user)
`ifdef DOWNSAMPLER_MC_FRAME_CHECK_EN
    , .err_framing(d4_err)
`endif
  );

  always #5 clk = ~clk;

  logic o_sready, o_valid, o_last;
  logic [1:0] o_user;
  logic [DW-1:0] o_data;
  logic [19:0] raw_pk, obs_pk;

  always_comb begin
    if (sel) begin
      o_sready = d4_sready; o_valid = d4_valid; o_last = d4_last;
      o_user = d4_user; o_data = d4_data;
    end else begin
      o_sready = d2_sready; o_valid = d2_valid; o_last = d2_last;
      o_user = {1'b0, d2_user}; o_data = d2_data;
    end
    raw_pk = {o_valid, o_user, o_last, o_data};
    obs_pk = o_valid ? raw_pk : 20'd0;
`ifdef DOWNSAMPLER_MC_FRAME_CHECK_EN
    o_err = sel ? d4_err : d2_err;
`endif
  end

  // Reference model: queue of beats the output port still owes, plus frame/group position.
  beat_t exp_q[$];
  int m_beat, m_fidx, m_ratio;
  int n_checks = 0;
  int n_fail = 0;
  logic pre_sready, exp_sready, acc_g;
  logic [19:0] exp_pk;

  function automatic int nch();
    return sel ? 4 : 2;
  endfunction

  function automatic int clamp_r(input int r);
    if (r == 0) return 1;
    if (r > MAX_R) return MAX_R;
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_beat = 0; m_fidx = 0;
    m_ratio = clamp_r(int'(cfg));
    acc_g = 1'b0;
    exp_pk = 20'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic cycle();
    #1;
    pre_sready = o_sready;
    exp_sready = (exp_q.size() == 0) || m_tready;
    acc_g = s_tvalid && exp_sready;
    if (exp_q.size() > 0 && m_tready) exp_q.delete(0);
    if (acc_g) begin
      if (m_fidx == m_ratio - 1) exp_q.push_back(beat_t'({2'(m_beat), s_tlast, s_tdata}));
      if (s_tlast) begin
        m_beat = 0;
        if (m_fidx == m_ratio - 1) begin
          m_fidx = 0;
          m_ratio = clamp_r(int'(cfg));
        end else begin
          m_fidx++;
        end
      end else if (m_beat < nch() - 1) begin
        m_beat++;
      end
    end
    @(posedge clk); @(negedge clk);
    exp_pk = (exp_q.size() > 0) ? {1'b1, exp_q[0]} : 20'd0;
  endtask

  task automatic test_reset();
    sel = 1'b0; cfg = 5'd3; m_tready = 1'b1;
    do_reset();
    n_checks++;
    if ({d2_valid, d2_user, d2_last, d2_data} !== 19'd0) begin
      n_fail++; $display("FAIL reset_out2: got %h expected 0", {d2_valid, d2_user, d2_last, d2_data});
    end
    n_checks++;
    if ({d4_valid, d4_user, d4_last, d4_data} !== 20'd0) begin
      n_fail++; $display("FAIL reset_out4: got %h expected 0", {d4_valid, d4_user, d4_last, d4_data});
    end
    n_checks++;
    if ({d2_sready, d4_sready} !== 2'b11) begin
      n_fail++; $display("FAIL reset_sready: got %b expected 11", {d2_sready, d4_sready});
    end
  endtask

  task automatic test_ratio3();
    beat_t got[$];
    logic [DW-1:0] ed [4] = '{16'd5, 16'd6, 16'd11, 16'd12};
    sel = 1'b0; cfg = 5'd3; m_tready = 1'b1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      s_tvalid = (i < 12); s_tdata = 16'(i + 1); s_tlast = (i % 2 == 1);
      cycle();
      n_checks++;
      if (obs_pk !== exp_pk) begin
        n_fail++; $display("FAIL r3_out cyc %0d: got %h expected %h", i, obs_pk, exp_pk);
      end
      if (o_valid) got.push_back(beat_t'(raw_pk[18:0]));
    end
    n_checks++;
    if (got.size() != 4) begin
      n_fail++; $display("FAIL r3_count: got %0d expected 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got[k] !== beat_t'({2'(k % 2), (k % 2 == 1), ed[k]})) begin
          n_fail++; $display("FAIL r3_beat %0d: got %h expected data %0d user/last %0d", k, got[k], ed[k], k % 2);
        end
      end
    end
  endtask

  task automatic test_ratio1();
    beat_t got[$];
    sel = 1'b1; cfg = 5'd1; m_tready = 1'b1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      s_tvalid = (i < 8); s_tdata = 16'(100 + i); s_tlast = (i % 4 == 3);
      cycle();
      n_checks++;
      if (pre_sready !== 1'b1 || obs_pk !== exp_pk) begin
        n_fail++; $display("FAIL r1_cyc %0d: got sready %b out %h expected 1 %h", i, pre_sready, obs_pk, exp_pk);
      end
      if (o_valid) got.push_back(beat_t'(raw_pk[18:0]));
    end
    n_checks++;
    if (got.size() != 8) begin
      n_fail++; $display("FAIL r1_count: got %0d expected 8", got.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (got[k] !== beat_t'({2'(k % 4), (k % 4 == 3), 16'(100 + k)})) begin
          n_fail++; $display("FAIL r1_beat %0d: got %h expected data %0d", k, got[k], 100 + k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    sel = 1'b1; cfg = 5'd1; m_tready = 1'b0;
    do_reset();
    s_tvalid = 1'b1; s_tdata = 16'd200; s_tlast = 1'b0;
    cycle();
    n_checks++;
    if (obs_pk !== {1'b1, 2'd0, 1'b0, 16'd200}) begin
      n_fail++; $display("FAIL bp_first: got %h expected %h", obs_pk, {1'b1, 2'd0, 1'b0, 16'd200});
    end
    s_tdata = 16'd201;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (pre_sready !== 1'b0 || obs_pk !== {1'b1, 2'd0, 1'b0, 16'd200}) begin
        n_fail++; $display("FAIL bp_hold %0d: got sready %b out %h expected 0 %h", i, pre_sready, obs_pk, {1'b1, 2'd0, 1'b0, 16'd200});
      end
    end
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = (i < 3); s_tdata = 16'(201 + i); s_tlast = (i == 2);
      cycle();
      n_checks++;
      if (i < 3 && obs_pk !== {1'b1, 2'(i + 1), (i == 2), 16'(201 + i)}) begin
        n_fail++; $display("FAIL bp_resume %0d: got %h expected data %0d", i, obs_pk, 201 + i);
      end else if (i == 3 && obs_pk !== 20'd0) begin
        n_fail++; $display("FAIL bp_drain: got %h expected 0", obs_pk);
      end
    end
  endtask

  task automatic test_ratio_change();
    beat_t got[$];
    int fr [6] = '{1, 5, 9, 10, 11, 12};
    sel = 1'b0; cfg = 5'd2; m_tready = 1'b1;
    do_reset();
    for (int f = 0; f < 14; f++) begin
      for (int b = 0; b < 2; b++) begin
        cfg = (f == 0) ? 5'd2 : ((f < 9) ? 5'd4 : 5'd0);
        s_tvalid = (f < 13); s_tdata = 16'(f * 2 + b); s_tlast = (b == 1);
        cycle();
        n_checks++;
        if (obs_pk !== exp_pk) begin
          n_fail++; $display("FAIL rc_out f%0d b%0d: got %h expected %h", f, b, obs_pk, exp_pk);
        end
        if (o_valid) got.push_back(beat_t'(raw_pk[18:0]));
      end
    end
    n_checks++;
    if (got.size() != 12) begin
      n_fail++; $display("FAIL rc_count: got %0d expected 12", got.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (got[2 * k].data !== 16'(fr[k] * 2)) begin
          n_fail++; $display("FAIL rc_frame %0d: got %0d expected %0d", k, got[2 * k].data, fr[k] * 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    beat_t got[$];
    sel = 1'b1; cfg = 5'd1; m_tready = 1'b0;
    do_reset();
    s_tvalid = 1'b1; s_tdata = 16'd300; s_tlast = 1'b0;
    cycle();
    n_checks++;
    if (obs_pk !== {1'b1, 2'd0, 1'b0, 16'd300}) begin
      n_fail++; $display("FAIL rm_pre: got %h expected %h", obs_pk, {1'b1, 2'd0, 1'b0, 16'd300});
    end
    cfg = 5'd2;
    do_reset();
    n_checks++;
    if (raw_pk !== 20'd0 || o_sready !== 1'b1) begin
      n_fail++; $display("FAIL rm_cleared: got out %h sready %b expected 0 1", raw_pk, o_sready);
    end
    m_tready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_tvalid = (i < 8); s_tdata = 16'(400 + i); s_tlast = (i % 4 == 3);
      cycle();
      n_checks++;
      if (obs_pk !== exp_pk) begin
        n_fail++; $display("FAIL rm_out %0d: got %h expected %h", i, obs_pk, exp_pk);
      end
      if (o_valid) got.push_back(beat_t'(raw_pk[18:0]));
    end
    n_checks++;
    if (got.size() != 4) begin
      n_fail++; $display("FAIL rm_count: got %0d expected 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got[k] !== beat_t'({2'(k), (k == 3), 16'(404 + k)})) begin
          n_fail++; $display("FAIL rm_beat %0d: got %h expected data %0d", k, got[k], 404 + k);
        end
      end
    end
  endtask

`ifdef DOWNSAMPLER_MC_FRAME_CHECK_EN
  task automatic test_framing();
    sel = 1'b1; cfg = 5'd1; m_tready = 1'b1;
    do_reset();
    n_checks++;
    if (o_err !== 1'b0) begin
      n_fail++; $display("FAIL fc_init: got %b expected 0", o_err);
    end
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1; s_tdata = 16'(500 + i); s_tlast = (i == 2);
      cycle();
      n_checks++;
      if (o_err !== (i == 2)) begin
        n_fail++; $display("FAIL fc_beat %0d: got %b expected %b", i, o_err, (i == 2));
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++;
      if (o_err !== 1'b1) begin
        n_fail++; $display("FAIL fc_sticky %0d: got %b expected 1", i, o_err);
      end
    end
    do_reset();
    n_checks++;
    if (o_err !== 1'b0) begin
      n_fail++; $display("FAIL fc_clear: got %b expected 0", o_err);
    end
  endtask
`endif

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      int dbeat;
      sel = (r == 1);
      cfg = 5'($urandom_range(1, 4)); m_tready = 1'b1;
      do_reset();
      dbeat = 0;
      for (int i = 0; i < 400; i++) begin
        if (!s_tvalid || acc_g) begin
          s_tvalid = ($urandom_range(0, 3) != 0);
          s_tdata  = 16'($urandom);
          s_tlast  = (dbeat == nch() - 1);
        end
        m_tready = ($urandom_range(0, 3) != 0);
        if (i > 0 && $urandom_range(0, 19) == 0)
          cfg = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 5));
        cycle();
        if (acc_g) dbeat = s_tlast ? 0 : dbeat + 1;
        n_checks++;
        if (obs_pk !== exp_pk || pre_sready !== exp_sready) begin
          n_fail++; $display("FAIL rnd%0d cyc %0d: got out %h sready %b expected %h %b", r, i, obs_pk, pre_sready, exp_pk, exp_sready);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; cfg = 5'd1; m_tready = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    test_reset();
    test_ratio3();
    test_ratio1();
    test_backpressure();
    test_ratio_change();
    test_reset_mid();
`ifdef DOWNSAMPLER_MC_FRAME_CHECK_EN
    test_framing();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/downsampler_mc.md
DOWNSAMPLER_MC -- requirements
Module: downsampler_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter NUM_CH, default 4, TDM channels per frame (>=1).
REQ-003 SHALL have parameter MAX_R, default 16, largest decimation ratio (>=1); CH_W = max(1,$clog2(NUM_CH)), R_W = $clog2(MAX_R+1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cfg_ratio  input  R_W  requested decimation ratio, in frames.
REQ-007 SHALL have port s_axis_in_tdata  input  DATA_WIDTH  signed sample.
REQ-008 SHALL have port s_axis_in_tvalid  input  1  input beat valid.
REQ-009 SHALL have port s_axis_in_tready  output  1  input beat accepted when high with tvalid.
REQ-010 SHALL have port s_axis_in_tlast  input  1  last channel of the current frame.
REQ-011 SHALL have port m_axis_out_tdata  output  DATA_WIDTH  signed decimated sample.
REQ-012 SHALL have port m_axis_out_tvalid  output  1  output beat valid.
REQ-013 SHALL have port m_axis_out_tready  input  1  downstream ready.
REQ-014 SHALL have port m_axis_out_tlast  output  1  copy of input tlast for the forwarded beat.
REQ-015 SHALL have port m_axis_out_tuser  output  CH_W  channel index of the forwarded beat.

Function
REQ-016 SHALL drive s_axis_in_tready = !m_axis_out_tvalid || m_axis_out_tready (combinational, one-deep output register).
REQ-017 SHALL keep channel counter ch: 0 after each accepted tlast beat, else +1 per accepted beat, saturating at NUM_CH-1.
REQ-018 SHALL keep frame counter fcnt: on each accepted tlast beat, fcnt+1, wrapping to 0 after ratio_act-1.
REQ-019 SHALL forward every accepted beat of a frame whose fcnt == ratio_act-1 and discard all other accepted beats.
REQ-020 SHALL present a forwarded beat on the m_axis_out outputs on the cycle after acceptance (latency 1), with tuser = ch and tlast = input tlast at acceptance.
REQ-021 SHALL hold m_axis_out_* stable while m_axis_out_tvalid && !m_axis_out_tready; no beat lost or duplicated.
REQ-022 SHALL clear m_axis_out_tvalid after an output handshake unless a new forwarded beat is accepted in the same cycle.
REQ-023 SHALL load ratio_act from cfg_ratio on the first cycle after reset and whenever fcnt wraps to 0; cfg_ratio changes at other times SHALL have no effect mid-group.
REQ-024 SHALL treat cfg_ratio 0 as 1 and clamp values above MAX_R to MAX_R; ratio 1 forwards every frame.
REQ-025 SHALL accept and discard beats of dropped frames at full rate, subject only to REQ-016.

Reset
REQ-026 SHALL, while reset is high, set ch=0, fcnt=0, ratio_act=1, m_axis_out_tvalid=0, m_axis_out_tdata=0, m_axis_out_tlast=0, m_axis_out_tuser=0.
REQ-027 SHALL discard any pending output beat and any partial frame on reset asserted mid-operation; the first frame after reset starts a new group.

Configuration
REQ-028 SHALL, when macro DOWNSAMPLER_MC_FRAME_CHECK_EN is defined, add output port err_framing (1 bit) set sticky when an accepted tlast beat has ch != NUM_CH-1 or an accepted non-tlast beat has ch == NUM_CH-1; cleared only by reset.
REQ-029 SHALL, when DOWNSAMPLER_MC_FRAME_CHECK_EN is undefined, omit err_framing and its logic; all other behaviour is identical.

Verification
REQ-030 SHALL test NUM_CH=2, cfg_ratio=3, m_tready=1, frames (1,2),(3,4),(5,6),(7,8),(9,10),(11,12) -> output exactly 5,6,11,12 with tuser 0,1,0,1 and tlast 0,1,0,1, each 1 cycle after input.
REQ-031 SHALL test cfg_ratio=1 with continuous input 100..107 (NUM_CH=4) -> all 8 beats forwarded in order, s_tready constantly 1.
REQ-032 SHALL test m_tready=0 for 5 cycles while a forwarded beat is valid -> tdata/tuser/tlast stable, s_tready=0, no input consumed; on m_tready=1 next beat follows without loss.
REQ-033 SHALL test cfg_ratio changed 2->4 mid-group -> current group still completes at 2; following groups forward every 4th frame; cfg_ratio=0 -> every frame.
REQ-034 SHALL test reset pulsed mid-frame with output valid -> next cycle m_tvalid=0, all outputs 0; subsequent group counts from frame 0.
REQ-035 SHALL test, with DOWNSAMPLER_MC_FRAME_CHECK_EN and NUM_CH=4, tlast on 3rd beat -> err_framing=1 from next cycle, stays 1 until reset.
